// File: rtl/fire_control_unit.sv
// Fire control sequencer: qualifies a radar track, locks, launches on pilot command,
// then cools down. The emergency alert forces ABORT from any state; RST overrides everything.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no threat; the only state where a magazine reload is accepted
// TRACK    | threat present, counting consecutive qualified cycles
// LOCKED   | target locked, waiting for the pilot trigger
// FIRE     | one-cycle launch strobe
// COOLDOWN | fixed post-launch hold-off
// ABORT    | emergency landing alert active
module fire_control_unit #(
    parameter int unsigned LOCK_CYCLES     = 4,
    parameter int unsigned COOLDOWN_CYCLES = 8,
    parameter int unsigned MAX_MISSILES    = 4,
    parameter logic [31:0] MIN_RANGE       = 32'd50,
    parameter logic [31:0] MAX_RANGE       = 32'd5000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        threat_detected,
    input  logic        safe_to_engage,
    input  logic [31:0] distance_to_target,
    input  logic        emergency_landing_alert,
    input  logic        pilot_fire_cmd,
    input  logic        reload_cmd,
    output logic        fire_pulse,
    output logic        lock_acquired,
    output logic        abort_active,
    output logic        dry_fire,
    output logic [2:0]  missiles_remaining,
    output logic [31:0] engage_distance,
    output logic [2:0]  FCU_state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TRACK    = 3'd1,
        ST_LOCKED   = 3'd2,
        ST_FIRE     = 3'd3,
        ST_COOLDOWN = 3'd4,
        ST_ABORT    = 3'd5
    } fcu_state_t;

    localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);
    localparam logic [15:0] COOL_LAST = 16'(COOLDOWN_CYCLES - 1);
    localparam logic [2:0]  MAG_FULL  = 3'(MAX_MISSILES);

    fcu_state_t  state;
    fcu_state_t  state_nxt;
    logic [15:0] lock_cnt;
    logic [15:0] cool_cnt;
    logic [31:0] fire_dist;
    logic        in_range;
    logic        qualified;

    assign in_range  = (distance_to_target >= MIN_RANGE) && (distance_to_target <= MAX_RANGE);
    assign qualified = threat_detected && safe_to_engage && in_range;
    assign FCU_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (threat_detected)
                    state_nxt = ST_TRACK;
            end
            ST_TRACK: begin
                if (!threat_detected)
                    state_nxt = ST_IDLE;
                else if (qualified && lock_cnt == LOCK_LAST)
                    state_nxt = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (!threat_detected)
                    state_nxt = ST_IDLE;
                else if (!qualified)
                    state_nxt = ST_TRACK;
                else if (pilot_fire_cmd && missiles_remaining != 3'd0)
                    state_nxt = ST_FIRE;
            end
            ST_FIRE: begin
                state_nxt = ST_COOLDOWN;
            end
            ST_COOLDOWN: begin
                if (cool_cnt == COOL_LAST)
                    state_nxt = threat_detected ? ST_TRACK : ST_IDLE;
            end
            ST_ABORT: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // The alert wins over every other transition, including holding in ABORT.
        if (emergency_landing_alert)
            state_nxt = ST_ABORT;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state              <= ST_IDLE;
            lock_cnt           <= '0;
            cool_cnt           <= '0;
            fire_dist          <= '0;
            missiles_remaining <= MAG_FULL;
            engage_distance    <= '0;
            fire_pulse         <= 1'b0;
            dry_fire           <= 1'b0;
            lock_acquired      <= 1'b0;
            abort_active       <= 1'b0;
        end else begin
            state         <= state_nxt;
            fire_pulse    <= (state_nxt == ST_FIRE);
            lock_acquired <= (state_nxt == ST_LOCKED);
            abort_active  <= (state_nxt == ST_ABORT);
            dry_fire      <= (state == ST_LOCKED) && (state_nxt == ST_LOCKED) &&
                             pilot_fire_cmd && (missiles_remaining == 3'd0);

            if (state == ST_TRACK && state_nxt == ST_TRACK && qualified)
                lock_cnt <= lock_cnt + 16'd1;
            else
                lock_cnt <= '0;

            if (state == ST_COOLDOWN && state_nxt == ST_COOLDOWN)
                cool_cnt <= cool_cnt + 16'd1;
            else
                cool_cnt <= '0;

            if (state != ST_FIRE && state_nxt == ST_FIRE)
                fire_dist <= distance_to_target;

            // Launch bookkeeping commits on leaving FIRE, whatever the next state is.
            if (state == ST_FIRE) begin
                engage_distance <= fire_dist;
                if (missiles_remaining != 3'd0)
                    missiles_remaining <= missiles_remaining - 3'd1;
            end else if (state == ST_IDLE && reload_cmd) begin
                missiles_remaining <= MAG_FULL;
            end
        end
    end

endmodule

// File: tb/tb_fire_control_unit.sv
// Directed bench for fire_control_unit with default parameters; expected values are hand-derived.
module tb_fire_control_unit;

    logic        CLK;
    logic        RST;
    logic        threat_detected;
    logic        safe_to_engage;
    logic [31:0] distance_to_target;
    logic        emergency_landing_alert;
    logic        pilot_fire_cmd;
    logic        reload_cmd;
    logic        fire_pulse;
    logic        lock_acquired;
    logic        abort_active;
    logic        dry_fire;
    logic [2:0]  missiles_remaining;
    logic [31:0] engage_distance;
    logic [2:0]  FCU_state;

    int checks = 0;
    int errors = 0;

    fire_control_unit dut (
        .CLK                     (CLK),
        .RST                     (RST),
        .threat_detected         (threat_detected),
        .safe_to_engage          (safe_to_engage),
        .distance_to_target      (distance_to_target),
        .emergency_landing_alert (emergency_landing_alert),
        .pilot_fire_cmd          (pilot_fire_cmd),
        .reload_cmd              (reload_cmd),
        .fire_pulse              (fire_pulse),
        .lock_acquired           (lock_acquired),
        .abort_active            (abort_active),
        .dry_fire                (dry_fire),
        .missiles_remaining      (missiles_remaining),
        .engage_distance         (engage_distance),
        .FCU_state               (FCU_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic clear_inputs();
        threat_detected         = 1'b0;
        safe_to_engage          = 1'b0;
        distance_to_target      = 32'd0;
        emergency_landing_alert = 1'b0;
        pilot_fire_cmd          = 1'b0;
        reload_cmd              = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        emergency_landing_alert = 1'b1;
        threat_detected = 1'b1;
        RST = 1'b1;
        tick(2);
        checks++;
        if (FCU_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", FCU_state);
        end
        checks++;
        if (missiles_remaining !== 3'd4) begin
            errors++;
            $display("FAIL reset_missiles: got %0d expected 4", missiles_remaining);
        end
        checks++;
        if ({fire_pulse, lock_acquired, abort_active, dry_fire} !== 4'b0000 || engage_distance !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got flags %b dist %0d expected 0000 / 0",
                     {fire_pulse, lock_acquired, abort_active, dry_fire}, engage_distance);
        end
        RST = 1'b0;
        clear_inputs();
        tick(1);
    endtask

    task automatic test_lock();
        apply_reset();
        threat_detected = 1'b1;
        safe_to_engage = 1'b1;
        distance_to_target = 32'd1000;
        tick(1);
        checks++;
        if (FCU_state !== 3'd1) begin
            errors++;
            $display("FAIL lock_track_entry: got %0d expected 1", FCU_state);
        end
        tick(3);
        checks++;
        if (FCU_state !== 3'd1 || lock_acquired !== 1'b0) begin
            errors++;
            $display("FAIL lock_early: got state %0d lock %b expected 1 / 0", FCU_state, lock_acquired);
        end
        tick(1);
        checks++;
        if (FCU_state !== 3'd2 || lock_acquired !== 1'b1) begin
            errors++;
            $display("FAIL lock_locked: got state %0d lock %b expected 2 / 1", FCU_state, lock_acquired);
        end
    endtask

    task automatic test_launch();
        int pulses;
        test_lock();
        distance_to_target = 32'd1200;
        pilot_fire_cmd = 1'b1;
        tick(1);
        checks++;
        if (FCU_state !== 3'd3 || fire_pulse !== 1'b1 || missiles_remaining !== 3'd4) begin
            errors++;
            $display("FAIL launch_fire: got state %0d pulse %b miss %0d expected 3 / 1 / 4",
                     FCU_state, fire_pulse, missiles_remaining);
        end
        pilot_fire_cmd = 1'b0;
        distance_to_target = 32'd1300;
        tick(1);
        checks++;
        if (FCU_state !== 3'd4 || fire_pulse !== 1'b0 || missiles_remaining !== 3'd3 ||
            engage_distance !== 32'd1200) begin
            errors++;
            $display("FAIL launch_commit: got state %0d pulse %b miss %0d dist %0d expected 4 / 0 / 3 / 1200",
                     FCU_state, fire_pulse, missiles_remaining, engage_distance);
        end
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            if (fire_pulse === 1'b1 || FCU_state !== 3'd4) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL launch_cooldown_hold: got %0d bad cycles expected 0", pulses);
        end
        tick(1);
        checks++;
        if (FCU_state !== 3'd1) begin
            errors++;
            $display("FAIL launch_cooldown_exit: got %0d expected 1", FCU_state);
        end
    endtask

    task automatic test_range_edges();
        apply_reset();
        threat_detected = 1'b1;
        safe_to_engage = 1'b1;
        distance_to_target = 32'd49;
        tick(10);
        checks++;
        if (FCU_state !== 3'd1 || lock_acquired !== 1'b0) begin
            errors++;
            $display("FAIL range_49: got state %0d lock %b expected 1 / 0", FCU_state, lock_acquired);
        end
        apply_reset();
        threat_detected = 1'b1;
        safe_to_engage = 1'b1;
        distance_to_target = 32'd50;
        tick(5);
        checks++;
        if (FCU_state !== 3'd2) begin
            errors++;
            $display("FAIL range_50: got %0d expected 2", FCU_state);
        end
        apply_reset();
        threat_detected = 1'b1;
        safe_to_engage = 1'b1;
        distance_to_target = 32'd5000;
        tick(5);
        checks++;
        if (FCU_state !== 3'd2) begin
            errors++;
            $display("FAIL range_5000: got %0d expected 2", FCU_state);
        end
        distance_to_target = 32'd5001;
        tick(1);
        checks++;
        if (FCU_state !== 3'd1 || lock_acquired !== 1'b0) begin
            errors++;
            $display("FAIL range_5001: got state %0d lock %b expected 1 / 0", FCU_state, lock_acquired);
        end
        safe_to_engage = 1'b0;
        distance_to_target = 32'd1000;
        tick(6);
        checks++;
        if (FCU_state !== 3'd1) begin
            errors++;
            $display("FAIL range_unsafe: got %0d expected 1", FCU_state);
        end
    endtask

    task automatic test_empty_magazine();
        int pulses;
        apply_reset();
        threat_detected = 1'b1;
        safe_to_engage = 1'b1;
        distance_to_target = 32'd1000;
        tick(5);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            pilot_fire_cmd = 1'b1;
            tick(1);
            if (fire_pulse === 1'b1) pulses++;
            pilot_fire_cmd = 1'b0;
            tick(1);
            tick(8);
            tick(4);
        end
        checks++;
        if (pulses !== 4 || missiles_remaining !== 3'd0 || FCU_state !== 3'd2) begin
            errors++;
            $display("FAIL empty_four_launches: got pulses %0d miss %0d state %0d expected 4 / 0 / 2",
                     pulses, missiles_remaining, FCU_state);
        end
        pilot_fire_cmd = 1'b1;
        tick(1);
        checks++;
        if (dry_fire !== 1'b1 || fire_pulse !== 1'b0 || FCU_state !== 3'd2 || missiles_remaining !== 3'd0) begin
            errors++;
            $display("FAIL empty_dry_fire: got dry %b pulse %b state %0d miss %0d expected 1 / 0 / 2 / 0",
                     dry_fire, fire_pulse, FCU_state, missiles_remaining);
        end
        pilot_fire_cmd = 1'b0;
        reload_cmd = 1'b1;
        tick(1);
        checks++;
        if (dry_fire !== 1'b0 || missiles_remaining !== 3'd0) begin
            errors++;
            $display("FAIL empty_reload_ignored: got dry %b miss %0d expected 0 / 0", dry_fire, missiles_remaining);
        end
        reload_cmd = 1'b0;
        threat_detected = 1'b0;
        tick(1);
        checks++;
        if (FCU_state !== 3'd0) begin
            errors++;
            $display("FAIL empty_to_idle: got %0d expected 0", FCU_state);
        end
        reload_cmd = 1'b1;
        tick(1);
        reload_cmd = 1'b0;
        checks++;
        if (missiles_remaining !== 3'd4) begin
            errors++;
            $display("FAIL empty_reload: got %0d expected 4", missiles_remaining);
        end
    endtask

    task automatic test_held_trigger();
        int pulses;
        apply_reset();
        threat_detected = 1'b1;
        safe_to_engage = 1'b1;
        distance_to_target = 32'd2000;
        tick(5);
        pilot_fire_cmd = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (fire_pulse === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 2 || FCU_state !== 3'd3) begin
            errors++;
            $display("FAIL held_refire: got pulses %0d state %0d expected 2 / 3", pulses, FCU_state);
        end
        pilot_fire_cmd = 1'b0;
        tick(1);
        checks++;
        if (missiles_remaining !== 3'd2) begin
            errors++;
            $display("FAIL held_count: got %0d expected 2", missiles_remaining);
        end
    endtask

    task automatic test_emergency();
        apply_reset();
        threat_detected = 1'b1;
        safe_to_engage = 1'b1;
        distance_to_target = 32'd1000;
        tick(3);
        emergency_landing_alert = 1'b1;
        tick(1);
        checks++;
        if (FCU_state !== 3'd5 || abort_active !== 1'b1) begin
            errors++;
            $display("FAIL emerg_track: got state %0d abort %b expected 5 / 1", FCU_state, abort_active);
        end
        tick(2);
        checks++;
        if (FCU_state !== 3'd5) begin
            errors++;
            $display("FAIL emerg_hold: got %0d expected 5", FCU_state);
        end
        emergency_landing_alert = 1'b0;
        tick(1);
        checks++;
        if (FCU_state !== 3'd0 || abort_active !== 1'b0) begin
            errors++;
            $display("FAIL emerg_release: got state %0d abort %b expected 0 / 0", FCU_state, abort_active);
        end
        tick(5);
        distance_to_target = 32'd777;
        pilot_fire_cmd = 1'b1;
        tick(1);
        checks++;
        if (FCU_state !== 3'd3) begin
            errors++;
            $display("FAIL emerg_pre_fire: got %0d expected 3", FCU_state);
        end
        pilot_fire_cmd = 1'b0;
        emergency_landing_alert = 1'b1;
        tick(1);
        checks++;
        if (FCU_state !== 3'd5 || missiles_remaining !== 3'd3 || engage_distance !== 32'd777) begin
            errors++;
            $display("FAIL emerg_fire: got state %0d miss %0d dist %0d expected 5 / 3 / 777",
                     FCU_state, missiles_remaining, engage_distance);
        end
        emergency_landing_alert = 1'b0;
        tick(1);
        checks++;
        if (FCU_state !== 3'd0) begin
            errors++;
            $display("FAIL emerg_fire_release: got %0d expected 0", FCU_state);
        end
    endtask

    task automatic test_reset_mid_cooldown();
        apply_reset();
        threat_detected = 1'b1;
        safe_to_engage = 1'b1;
        distance_to_target = 32'd1500;
        tick(5);
        for (int i = 0; i < 3; i++) begin
            pilot_fire_cmd = 1'b1;
            tick(1);
            pilot_fire_cmd = 1'b0;
            tick(1);
            if (i < 2) tick(12);
        end
        tick(3);
        checks++;
        if (FCU_state !== 3'd4 || missiles_remaining !== 3'd1) begin
            errors++;
            $display("FAIL midcool_setup: got state %0d miss %0d expected 4 / 1", FCU_state, missiles_remaining);
        end
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        checks++;
        if (FCU_state !== 3'd0 || missiles_remaining !== 3'd4 || engage_distance !== 32'd0) begin
            errors++;
            $display("FAIL midcool_reset: got state %0d miss %0d dist %0d expected 0 / 4 / 0",
                     FCU_state, missiles_remaining, engage_distance);
        end
    endtask

    initial begin
        RST = 1'b1;
        clear_inputs();
        test_reset();
        test_lock();
        test_launch();
        test_range_edges();
        test_empty_magazine();
        test_held_trigger();
        test_emergency();
        test_reset_mid_cooldown();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
